// File: rtl/rtype_exec_ctrl.sv
// R-type issue/writeback controller wrapped around an external combinational ALU.
// Owns the 32x32 register file; one instruction retires every four cycles.
module rtype_exec_ctrl #(
  parameter int CHECK_OPCODE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        ld_en,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [4:0]  alu_shamt,
  output logic [5:0]  alu_funct,
  input  logic [31:0] alu_result,
  output logic        done,
  output logic [31:0] result,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [5:0] FN_ADD = 6'b001001;
  localparam logic [5:0] FN_SUB = 6'b001010;
  localparam logic [5:0] FN_OR  = 6'b010010;
  localparam logic [5:0] FN_SRL = 6'b100010;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state_reg, state_next;

  logic [5:0]  op_reg, funct_reg;
  logic [4:0]  rs_reg, rt_reg, rd_reg, shamt_reg;

  logic [31:0] src1_reg, src2_reg, result_reg;
  logic [4:0]  alu_shamt_reg;
  logic [5:0]  alu_funct_reg;
  logic        illegal_reg;

  logic [31:0] regs [32];
  logic [31:0] load_sel, wb_sel;

  logic        accept, load_we, wb_we;
  logic        funct_ok, opcode_bad, decode_illegal;

  assign accept  = (state_reg == IDLE) && !ld_en && instr_valid;
  assign load_we = (state_reg == IDLE) && ld_en;
  assign wb_we   = (state_reg == WB) && !illegal_reg;

  always_comb begin
    funct_ok = 1'b0;
    case (funct_reg)
      FN_ADD, FN_SUB, FN_OR, FN_SRL: funct_ok = 1'b1;
      default:                      funct_ok = 1'b0;
    endcase
  end

  assign opcode_bad     = (CHECK_OPCODE != 0) && (op_reg != 6'b000000);
  assign decode_illegal = !funct_ok || opcode_bad;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Per-register write selects; entry 0 is never selected so r0 stays zero.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sel
      if (gi == 0) begin : g_zero
        assign load_sel[gi] = 1'b0;
        assign wb_sel[gi]   = 1'b0;
      end else begin : g_reg
        assign load_sel[gi] = load_we && (ld_addr == 5'(gi));
        assign wb_sel[gi]   = wb_we && (rd_reg == 5'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (load_sel[i])    regs[i] <= ld_data;
        else if (wb_sel[i]) regs[i] <= result_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg        <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      rd_reg        <= '0;
      shamt_reg     <= '0;
      funct_reg     <= '0;
      src1_reg      <= '0;
      src2_reg      <= '0;
      alu_shamt_reg <= '0;
      alu_funct_reg <= '0;
      illegal_reg   <= 1'b0;
      result_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg    <= instr[31:26];
            rs_reg    <= instr[25:21];
            rt_reg    <= instr[20:16];
            rd_reg    <= instr[15:11];
            shamt_reg <= instr[10:6];
            funct_reg <= instr[5:0];
          end
        end
        READ: begin
          src1_reg      <= regs[rs_reg];
          src2_reg      <= regs[rt_reg];
          alu_shamt_reg <= shamt_reg;
          // Illegal instructions present a neutral funct so the ALU sees no real op.
          alu_funct_reg <= decode_illegal ? 6'b000000 : funct_reg;
          illegal_reg   <= decode_illegal;
        end
        EXEC: result_reg <= alu_result;
        default: ;
      endcase
    end
  end

  assign instr_ready = (state_reg == IDLE) && !ld_en;
  assign alu_src1    = src1_reg;
  assign alu_src2    = src2_reg;
  assign alu_shamt   = alu_shamt_reg;
  assign alu_funct   = alu_funct_reg;
  assign done        = (state_reg == WB);
  assign result      = result_reg;
  assign illegal     = done && illegal_reg;
  assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Randomized self-checking bench: behavioural ALU plus an architectural
// register-file model compared against every retired instruction.
module tb_rtype_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic        done;
  logic [31:0] result;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rm [32];

  always #5 clk = ~clk;

  rtype_exec_ctrl #(.CHECK_OPCODE(1)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_shamt(alu_shamt),
    .alu_funct(alu_funct), .alu_result(alu_result),
    .done(done), .result(result), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural combinational ALU.
  always_comb begin
    case (alu_funct)
      6'b001001: alu_result = alu_src1 + alu_src2;
      6'b001010: alu_result = alu_src1 - alu_src2;
      6'b010010: alu_result = alu_src1 | alu_src2;
      6'b100010: alu_result = alu_src1 >> alu_shamt;
      default:   alu_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // Architectural meaning of one instruction against the model register file.
  task automatic ref_exec(input logic [31:0] ins, output logic [31:0] res, output logic ill);
    logic [31:0] a, b;
    a   = rm[ins[25:21]];
    b   = rm[ins[20:16]];
    ill = (ins[31:26] != 6'd0);
    res = 32'd0;
    case (ins[5:0])
      6'b001001: res = a + b;
      6'b001010: res = a - b;
      6'b010010: res = a | b;
      6'b100010: res = a >> ins[10:6];
      default:   ill = 1'b1;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0; dbg_addr = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) rm[i] = 32'd0;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    #1 check("ld.rdy_low", 32'(instr_ready), 32'd0);
    @(negedge clk);
    ld_en = 1'b0;
    if (a != 5'd0) rm[a] = d;
    dbg_addr = a;
    #1 check($sformatf("ld.dbg r%0d", a), dbg_data, rm[a]);
  endtask

  // Called at a negedge with the controller idle; checks all four phases.
  task automatic run_instr(input logic [31:0] ins, input string tag);
    logic [31:0] er;
    logic        ei;
    ref_exec(ins, er, ei);
    instr = ins; instr_valid = 1'b1;
    #1 check({tag, ".rdy"}, 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    check({tag, ".read_rdy"}, 32'(instr_ready), 32'd0);
    check({tag, ".read_done"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, ".exec_rdy"}, 32'(instr_ready), 32'd0);
    check({tag, ".exec_done"}, 32'(done), 32'd0);
    check({tag, ".exec_src1"}, alu_src1, rm[ins[25:21]]);
    check({tag, ".exec_src2"}, alu_src2, rm[ins[20:16]]);
    check({tag, ".exec_shamt"}, 32'(alu_shamt), 32'(ins[10:6]));
    check({tag, ".exec_funct"}, 32'(alu_funct), ei ? 32'd0 : 32'(ins[5:0]));
    @(negedge clk);
    check({tag, ".wb_rdy"}, 32'(instr_ready), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".illegal"}, 32'(illegal), 32'(ei));
    if (!ei) check({tag, ".result"}, result, er);
    if (!ei && ins[15:11] != 5'd0) rm[ins[15:11]] = er;
    @(negedge clk);
    check({tag, ".post_done"}, 32'(done), 32'd0);
    check({tag, ".post_rdy"}, 32'(instr_ready), 32'd1);
    dbg_addr = ins[15:11];
    #1 check({tag, ".dbg_rd"}, dbg_data, rm[ins[15:11]]);
    dbg_addr = 5'd0;
    #1 check({tag, ".dbg_r0"}, dbg_data, 32'd0);
    $display("instr %s %h -> result %h illegal %0b", tag, ins, result, ei);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    logic [5:0]  fn_tab [5];
    fn_tab[0] = 6'b001001; fn_tab[1] = 6'b001010; fn_tab[2] = 6'b010010;
    fn_tab[3] = 6'b100010; fn_tab[4] = 6'b100000;

    do_reset();
    #1;
    check("rst.done", 32'(done), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.rdy", 32'(instr_ready), 32'd1);
    check("rst.src1", alu_src1, 32'd0);
    check("rst.src2", alu_src2, 32'd0);
    check("rst.shamt", 32'(alu_shamt), 32'd0);
    check("rst.funct", 32'(alu_funct), 32'd0);
    check("rst.result", result, 32'd0);
    @(negedge clk);

    // Directed cases from the test plan
    load(5'd1, 32'd5);
    load(5'd2, 32'd3);
    run_instr(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001001), "add");
    run_instr(mk(6'd0, 5'd2, 5'd1, 5'd4, 5'd0, 6'b001010), "sub");
    run_instr(mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'b010010), "or");
    load(5'd5, 32'h8000_0000);
    run_instr(mk(6'd0, 5'd5, 5'd0, 5'd7, 5'd4, 6'b100010), "srl");
    run_instr(mk(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b001001), "add_rd0");
    run_instr(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), "bad_funct");
    run_instr(mk(6'b000010, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001001), "bad_op");
    load(5'd0, 32'hDEAD_BEEF);

    // Load and instruction offered together: load wins, instruction next cycle
    ld_en = 1'b1; ld_addr = 5'd8; ld_data = 32'h0000_0100;
    instr = mk(6'd0, 5'd8, 5'd1, 5'd9, 5'd0, 6'b001001); instr_valid = 1'b1;
    #1 check("simul.rdy_low", 32'(instr_ready), 32'd0);
    @(negedge clk);
    ld_en = 1'b0; rm[8] = 32'h0000_0100;
    run_instr(mk(6'd0, 5'd8, 5'd1, 5'd9, 5'd0, 6'b001001), "simul_add");

    // Reset while in EXEC aborts the instruction
    do_reset();
    load(5'd1, 32'd5);
    load(5'd2, 32'd3);
    instr = mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001001); instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    check("abort.in_exec", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) rm[i] = 32'd0;
    check("abort.done", 32'(done), 32'd0);
    check("abort.rdy", 32'(instr_ready), 32'd1);
    @(negedge clk);
    check("abort.done2", 32'(done), 32'd0);
    dbg_addr = 5'd3;
    #1 check("abort.r3", dbg_data, 32'd0);

    // Randomized mix
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(3) == 0)
        load(5'($urandom_range(31)), $urandom);
      ins = mk(($urandom_range(7) == 0) ? 6'($urandom_range(63, 1)) : 6'd0,
               5'($urandom_range(31)), 5'($urandom_range(31)),
               5'($urandom_range(31)), 5'($urandom_range(31)),
               ($urandom_range(9) == 0) ? 6'($urandom_range(63)) : fn_tab[$urandom_range(4)]);
      run_instr(ins, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rtype_exec_ctrl.md
Name: rtype_exec_ctrl

Overview:
- Multi-cycle R-type issue/writeback controller that sits directly around the combinational ALU.
- It owns the 32x32 register file and accepts one 32-bit R-type instruction per handshake.
- It reads rs/rt, drives the ALU operand/Shamt/Funct ports from registers, captures ALUresult, and writes it back to rd.
- It also provides a register preload port and a debug read port for benches.

Parameters:
CHECK_OPCODE, 1, when 1 an instruction with instr[31:26] != 6'b000000 is flagged illegal; when 0 the opcode field is ignored.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
instr_valid  input  1  instruction offered
instr  input  32  {op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]}
instr_ready  output  1  controller can accept instruction
ld_en  input  1  register preload strobe
ld_addr  input  5  preload register index
ld_data  input  32  preload value
alu_src1  output  32  to ALU Src1 (registered rs value)
alu_src2  output  32  to ALU Src2 (registered rt value)
alu_shamt  output  5  to ALU Shamt
alu_funct  output  6  to ALU Funct
alu_result  input  32  from ALU ALUresult
done  output  1  one-cycle pulse, instruction retired
result  output  32  value retired, valid while done=1
illegal  output  1  valid while done=1; instruction not supported, no writeback
dbg_addr  input  5  debug read index
dbg_data  output  32  combinational read of regfile[dbg_addr]; reads 0 for index 0

Behaviour:
- Reset: one clock is used; reset is synchronous and active-high (rst sampled on posedge clk).
- On reset, state=IDLE, all 32 registers=0, alu_src1/alu_src2/result=0, alu_shamt=0, alu_funct=0, done=0, illegal=0.
- Reset asserted in any state aborts the in-flight instruction: no writeback and no done pulse.
- FSM states and transitions:
  - IDLE: instr_ready = !ld_en.
    - If ld_en=1: regfile[ld_addr] <= ld_data, except when ld_addr=0; no instruction is accepted that cycle.
    - Else if instr_valid=1: latch the instruction fields, go to READ.
  - READ: alu_src1 <= R[rs]; alu_src2 <= R[rt]; alu_shamt <= shamt.
    - alu_funct <= funct if the instruction is legal, else 6'b000000.
    - Compute the illegal flag, then go to EXEC.
  - EXEC: ALU ports are stable; capture result <= alu_result, then go to WB.
  - WB: if !illegal && rd!=0, regfile[rd] <= result. done=1 for this cycle only, then go to IDLE.
- Legal funct codes: 6'b001001 add, 6'b001010 sub, 6'b010010 or, 6'b100010 srl (rs >> shamt).
  - Any other funct sets illegal=1; with CHECK_OPCODE=1, op!=0 also sets illegal=1.
  - On an illegal instruction, result is whatever was captured from the ALU and is don't-care; the register file is unchanged.
- Latency: instruction accepted on edge t, done high in cycle t+3. Throughput is one instruction per 4 cycles; instr_ready=0 in READ/EXEC/WB.
- ld_en outside IDLE is ignored.
- Register 0 always reads 0 and is never written.
- Operands are read in READ from the current register file. The prior instruction's WB completes before IDLE, so no bypass is needed.
- Arithmetic is done by the ALU, modulo 2^32, with no overflow flag. The controller never changes ALU inputs during EXEC.
- alu_* outputs hold their last value in IDLE.

Test Plan:
- Reset, then ld r1=5, r2=3; issue add rs=1 rt=2 rd=3 -> instr_ready low for 3 cycles; done at t+3 with result=8, illegal=0; dbg r3=8.
- Same preload; sub rs=2 rt=1 rd=4 -> result=0xFFFFFFFE, r4=0xFFFFFFFE; or r1|r2 into rd=6 -> result=7.
- ld r5=0x80000000; srl rs=5 shamt=4 rd=7 -> result=0x08000000, r7=0x08000000; alu_shamt=4 seen during EXEC.
- add with rd=0 -> done pulses with result=8; dbg r0 still reads 0.
- Illegal cases:
  - funct=6'b100000 with rd=3 -> done, illegal=1, r3 unchanged.
  - op=6'b000010 with CHECK_OPCODE=1 -> illegal=1.
- Simultaneous and mid-operation events:
  - ld_en=1 with instr_valid=1 in IDLE -> load performed, instr_ready=0, instruction accepted the following cycle.
  - rst asserted in EXEC -> no done, r3 stays 0, state IDLE next cycle.
